// File: rtl/dvbc_pkg.sv
// Shared DVB-C framing constants and interleaver geometry helpers.
package dvbc_pkg;
  localparam int          DVBC_PKT_LEN  = 204;
  localparam logic [7:0]  DVBC_SYNC     = 8'h47;
  localparam logic [7:0]  DVBC_SYNC_INV = 8'hB8;
  localparam int          DVBC_IL_I     = 12;
  localparam int          DVBC_IL_M     = 17;

  // Start address of branch j's delay line inside the shared storage.
  function automatic int il_base(input int j);
    return DVBC_IL_M * j * (j - 1) / 2;
  endfunction
endpackage

// File: rtl/dvbc_interleaver_ram.sv
// Single-port read-first byte RAM backing all interleaver delay lines.
module dvbc_interleaver_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 1122,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      dout <= mem[addr];
      if (we) mem[addr] <= din;
    end
  end
endmodule

// File: rtl/dvbc_conv_interleaver.sv
// Forney convolutional byte interleaver (I=12, M=17) between RS encoder and mapper.
module dvbc_conv_interleaver import dvbc_pkg::*; #(
  parameter int I         = DVBC_IL_I,
  parameter int M         = DVBC_IL_M,
  parameter int W         = 8,
  parameter int MEM_DEPTH = M * I * (I - 1) / 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_sop,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         out_sop,
  input  logic         out_ready,
  output logic         sync_err
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int BW = $clog2(I);
  localparam int PW = $clog2(I * M);

  logic [BW-1:0]         branch_q, branch_d, out_br_q, out_br_d, pkt_cnt_q, pkt_cnt_d, cur_br;
  logic [I-1:0][PW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]          data_q, data_d, ram_dout;
  logic                  seen_sop_q, seen_sop_d, mask_q, mask_d;
  logic                  out_valid_q, out_valid_d, out_sop_q, out_sop_d, sync_err_q, sync_err_d;
  logic                  accept, ram_en;
  logic [AW-1:0]         ram_addr;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign cur_br   = in_sop ? '0 : branch_q;
  assign ram_en   = accept && (cur_br != '0);
  assign ram_addr = AW'(il_base(int'(cur_br))) + AW'(ptr_q[cur_br]);

  always_comb begin
    branch_d    = branch_q;
    ptr_d       = ptr_q;
    pkt_cnt_d   = pkt_cnt_q;
    seen_sop_d  = seen_sop_q;
    data_d      = data_q;
    out_br_d    = out_br_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    sync_err_d  = accept && in_sop && (branch_q != '0);
    if (in_ready) begin
      out_valid_d = accept;
      out_sop_d   = accept && in_sop;
    end
    if (accept) begin
      branch_d = (cur_br == BW'(I - 1)) ? '0 : cur_br + 1'b1;
      out_br_d = cur_br;
      data_d   = in_data;
      // pkt_cnt holds packets seen before the current one, so branch j is live once j packets passed
      mask_d   = cur_br > pkt_cnt_q;
      if (cur_br != '0)
        ptr_d[cur_br] = (ptr_q[cur_br] == PW'(int'(cur_br) * M - 1)) ? '0 : ptr_q[cur_br] + 1'b1;
      if (in_sop) begin
        seen_sop_d = 1'b1;
        if (seen_sop_q && pkt_cnt_q != BW'(I - 1)) pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q    <= '0;
      ptr_q       <= '0;
      pkt_cnt_q   <= '0;
      seen_sop_q  <= 1'b0;
      data_q      <= '0;
      out_br_q    <= '0;
      mask_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      branch_q    <= branch_d;
      ptr_q       <= ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      seen_sop_q  <= seen_sop_d;
      data_q      <= data_d;
      out_br_q    <= out_br_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      sync_err_q  <= sync_err_d;
    end
  end

  dvbc_interleaver_ram #(.W(W), .DEPTH(MEM_DEPTH)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_en),
    .addr (ram_addr),
    .din  (in_data),
    .dout (ram_dout)
  );

  assign out_data  = (out_br_q == '0) ? data_q : (mask_q ? '0 : ram_dout);
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign sync_err  = sync_err_q;
endmodule

// File: tb/tb_dvbc_conv_interleaver.sv
// Scoreboard bench: driver pushes golden-model bytes, monitor pops on each output transfer.
module tb_dvbc_conv_interleaver;
  import dvbc_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data = '0, out_data;
  logic       in_valid = 1'b0, in_sop = 1'b0, in_ready;
  logic       out_valid, out_sop, sync_err, out_ready = 1'b1;

  always #5 clk = ~clk;

  dvbc_conv_interleaver dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_ready(out_ready), .sync_err(sync_err)
  );

  int n_chk = 0, n_pass = 0;
  logic [8:0] exp_q[$];
  int hist[12][4096];
  int wcnt[12];
  int mbr = 0, exp_serr = 0, exp_sop = 0, seen_serr = 0, seen_sop = 0, stall_cnt = 0;
  bit rnd_gap = 0, rnd_rdy = 0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
  endtask

  // Golden model: branch j returns the byte written to it j*17 writes earlier, or 0 if none yet.
  task automatic model_push(input logic [7:0] d, input bit sop);
    int b, n, e;
    b = sop ? 0 : mbr;
    if (sop && mbr != 0) exp_serr++;
    if (b == 0) e = d;
    else begin
      n = wcnt[b];
      hist[b][n] = d;
      wcnt[b]++;
      e = (n >= b * 17) ? hist[b][n - b * 17] : 0;
    end
    mbr = (b == 11) ? 0 : b + 1;
    if (sop) exp_sop++;
    exp_q.push_back({sop, 8'(e)});
  endtask

  function automatic logic [7:0] pbyte(input int p, input int k, input bit pat);
    if (k == 0) return (pat && p % 8 == 0) ? DVBC_SYNC_INV : DVBC_SYNC;
    return pat ? 8'((k + 13 * p) & 255) : 8'(k);
  endfunction

  task automatic send(input logic [7:0] d, input bit sop);
    int t = 0;
    if (rnd_gap) while ($urandom_range(1) == 1) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_sop = sop;
    #1;
    while (!in_ready) begin
      @(negedge clk); #1; t++;
      if (t > 1000) begin
        $display("FAIL in_ready_timeout: got 0 for 1000 cycles, expected 1");
        $fatal(1, "bench stopped");
      end
    end
    model_push(d, sop);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int nbytes, input bit pat, input int stall_at);
    for (int k = 0; k < nbytes; k++) begin
      send(pbyte(p, k, pat), k == 0);
      if (k == stall_at) stall_cnt = 5;
    end
  endtask

  task automatic drain(input int cyc);
    repeat (cyc) @(negedge clk);
    #3;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_in_ready", in_ready, 1);
    exp_q.delete();
    for (int j = 0; j < 12; j++) wcnt[j] = 0;
    mbr = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (stall_cnt > 0) begin out_ready = 1'b0; stall_cnt--; end
      else out_ready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  initial begin
    bit pacc = 0, pst = 0;
    logic [7:0] pd = '0;
    logic [8:0] e;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        pacc = 0; pst = 0;
      end else begin
        if (pacc) check("valid_after_accept", out_valid, 1);
        if (pst) check("stall_hold", {out_valid, out_data}, {1'b1, pd});
        if (sync_err) seen_serr++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_output", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("out_sop_data", {out_sop, out_data}, e);
            if (out_sop) seen_sop++;
          end
        end
        pst = out_valid && !out_ready;
        if (pst) begin
          check("stall_in_ready", in_ready, 0);
          pd = out_data;
        end
        pacc = in_valid && in_ready;
      end
    end
  end

  initial begin
    for (int j = 0; j < 12; j++) wcnt[j] = 0;
    do_reset();
    // Priming from reset with the plain k mod 256 pattern.
    for (int p = 0; p < 12; p++) send_pkt(p, 204, 0, -1);
    // Forced 5-cycle back-pressure mid-packet.
    send_pkt(12, 204, 1, 60);
    send_pkt(13, 204, 1, -1);
    // Early sync at byte 100 (commutator on branch 4).
    send_pkt(14, 100, 1, -1);
    send_pkt(15, 204, 1, -1);
    drain(5);
    check("sync_err_pulses", seen_serr, exp_serr);
    // Reset inside the sixth packet, then a fresh run that must show priming zeros.
    for (int p = 0; p < 5; p++) send_pkt(20 + p, 204, 1, -1);
    send_pkt(25, 100, 1, -1);
    drain(4);
    do_reset();
    for (int p = 0; p < 12; p++) send_pkt(30 + p, 204, 1, -1);
    // Random input gaps and output back-pressure.
    rnd_gap = 1; rnd_rdy = 1;
    for (int p = 0; p < 50; p++) send_pkt(50 + p, 204, 1, -1);
    rnd_gap = 0; rnd_rdy = 0;
    drain(20);
    check("sop_count", seen_sop, exp_sop);
    check("sync_err_total", seen_serr, exp_serr);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
